// File: rtl/fill_rect_cmd_decoder.sv
// Pulls three-word fill-rect commands from the command FIFO, decodes them and hands them to the fill generator.
// Optional off-screen clipping is compiled in with `define FILL_RECT_CLIP_EN.
module fill_rect_cmd_decoder #(
    parameter int ROW_STRIDE = 240,
    parameter int SCREEN_WID = 240,
    parameter int SCREEN_HGT = 320
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_fifo_rts,
    output logic        o_cmd_fifo_rtr,
    input  logic [31:0] i_cmd_fifo_data,
    input  logic        i_data_gen_is_idle,
    output logic        o_gen_start_strobe,
    output logic [15:0] o_init_addr,
    output logic [15:0] o_cmd_data_hgt,
    output logic [15:0] o_cmd_data_wid,
    output logic [3:0]  o_cmd_data_rval,
    output logic [3:0]  o_cmd_data_gval,
    output logic [3:0]  o_cmd_data_bval,
    output logic        o_decoder_busy,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [2:0] {
        S_W0,
        S_W1,
        S_W2,
        S_CHECK,
        S_ISSUE,
        S_BUSY
    } state_t;

    localparam logic [3:0] OPC_FILL_RECT = 4'h1;

    state_t      r_state;
    state_t      w_next;

    logic        r_rtr;
    logic        r_strobe;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_wid;
    logic [15:0] r_hgt;
    logic [3:0]  r_rval;
    logic [3:0]  r_gval;
    logic [3:0]  r_bval;
    logic [15:0] r_init_addr;
    logic [7:0]  r_drop_cnt;

    logic        w_xfer;
    logic        w_latch_rgb;
    logic        w_latch_xy;
    logic        w_latch_sz;
    logic        w_load_addr;
    logic        w_drop;
    logic        w_zero_size;
    logic        w_offscreen;
    logic [15:0] w_new_wid;
    logic [15:0] w_new_hgt;
    logic [15:0] w_row_off;
    logic [15:0] w_col_off;
    logic [15:0] w_addr;

    assign w_xfer      = i_cmd_fifo_rts & r_rtr;
    assign w_zero_size = (r_wid == 16'd0) || (r_hgt == 16'd0);

    // Row offset is formed at 32 bits and truncated, so the address wraps modulo 2^16.
    assign w_row_off = 16'(32'(r_y) * 32'(ROW_STRIDE));
    assign w_col_off = {3'b000, r_x[15:3]} * 16'd3;
    assign w_addr    = w_row_off + w_col_off;

`ifdef FILL_RECT_CLIP_EN
    logic [15:0] w_wid_room;
    logic [15:0] w_hgt_room;

    assign w_wid_room  = 16'(SCREEN_WID) - r_x;
    assign w_hgt_room  = 16'(SCREEN_HGT) - r_y;
    assign w_offscreen = (r_x >= 16'(SCREEN_WID)) || (r_y >= 16'(SCREEN_HGT));
    assign w_new_wid   = (r_wid > w_wid_room) ? w_wid_room : r_wid;
    assign w_new_hgt   = (r_hgt > w_hgt_room) ? w_hgt_room : r_hgt;
`else
    logic [15:0] w_unused_dims;

    assign w_unused_dims = 16'(SCREEN_WID) ^ 16'(SCREEN_HGT);
    assign w_offscreen   = 1'b0;
    assign w_new_wid     = r_wid;
    assign w_new_hgt     = r_hgt;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_W0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_latch_rgb = 1'b0;
        w_latch_xy  = 1'b0;
        w_latch_sz  = 1'b0;
        w_load_addr = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_W0: begin
                if (w_xfer) begin
                    if (i_cmd_fifo_data[31:28] == OPC_FILL_RECT) begin
                        w_latch_rgb = 1'b1;
                        w_next      = S_W1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_W1: begin
                if (w_xfer) begin
                    w_latch_xy = 1'b1;
                    w_next     = S_W2;
                end
            end
            S_W2: begin
                if (w_xfer) begin
                    w_latch_sz = 1'b1;
                    w_next     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_zero_size || w_offscreen) begin
                    w_drop = 1'b1;
                    w_next = S_W0;
                end else begin
                    w_load_addr = 1'b1;
                    w_next      = S_ISSUE;
                end
            end
            // Strobe is held while the generator stays idle, e.g. stalled by its arbiter.
            S_ISSUE: begin
                if (!i_data_gen_is_idle) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_data_gen_is_idle) begin
                    w_next = S_W0;
                end
            end
            default: begin
                w_next = S_W0;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rtr    <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_rtr    <= (w_next == S_W0) || (w_next == S_W1) || (w_next == S_W2);
            r_strobe <= (w_next == S_ISSUE);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rval      <= 4'd0;
            r_gval      <= 4'd0;
            r_bval      <= 4'd0;
            r_x         <= 16'd0;
            r_y         <= 16'd0;
            r_wid       <= 16'd0;
            r_hgt       <= 16'd0;
            r_init_addr <= 16'd0;
        end else begin
            if (w_latch_rgb) begin
                r_rval <= i_cmd_fifo_data[11:8];
                r_gval <= i_cmd_fifo_data[7:4];
                r_bval <= i_cmd_fifo_data[3:0];
            end
            if (w_latch_xy) begin
                r_x <= i_cmd_fifo_data[31:16];
                r_y <= i_cmd_fifo_data[15:0];
            end
            if (w_latch_sz) begin
                r_wid <= i_cmd_fifo_data[31:16];
                r_hgt <= i_cmd_fifo_data[15:0];
            end
            if (w_load_addr) begin
                r_init_addr <= w_addr;
                r_wid       <= w_new_wid;
                r_hgt       <= w_new_hgt;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_cmd_fifo_rtr     = r_rtr;
    assign o_gen_start_strobe = r_strobe;
    assign o_init_addr        = r_init_addr;
    assign o_cmd_data_wid     = r_wid;
    assign o_cmd_data_hgt     = r_hgt;
    assign o_cmd_data_rval    = r_rval;
    assign o_cmd_data_gval    = r_gval;
    assign o_cmd_data_bval    = r_bval;
    assign o_decoder_busy     = (r_state != S_W0);
    assign o_drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_fill_rect_cmd_decoder.sv
// Directed testbench for fill_rect_cmd_decoder; expected values are hand-computed from the command words.
`timescale 1ns/1ps
module tb_fill_rect_cmd_decoder;

    logic        clk;
    logic        rst;
    logic        rts;
    logic        rtr;
    logic [31:0] data;
    logic        genIdle;
    logic        strobe;
    logic [15:0] initAddr;
    logic [15:0] hgt;
    logic [15:0] wid;
    logic [3:0]  rval;
    logic [3:0]  gval;
    logic [3:0]  bval;
    logic        busy;
    logic [7:0]  dropCnt;

    int checkCount = 0;
    int errorCount = 0;
    int expDrop    = 0;

    fill_rect_cmd_decoder #(
        .ROW_STRIDE(240),
        .SCREEN_WID(240),
        .SCREEN_HGT(320)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_cmd_fifo_rts     (rts),
        .o_cmd_fifo_rtr     (rtr),
        .i_cmd_fifo_data    (data),
        .i_data_gen_is_idle (genIdle),
        .o_gen_start_strobe (strobe),
        .o_init_addr        (initAddr),
        .o_cmd_data_hgt     (hgt),
        .o_cmd_data_wid     (wid),
        .o_cmd_data_rval    (rval),
        .o_cmd_data_gval    (gval),
        .o_cmd_data_bval    (bval),
        .o_decoder_busy     (busy),
        .o_drop_cnt         (dropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one word and returns 1ns after the edge that transfers it.
    task automatic applyStimulus(input logic [31:0] word);
        int waitCycles = 0;
        @(negedge clk);
        rts  = 1'b1;
        data = word;
        while (!rtr && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("rtr_wait", {31'd0, rtr}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        applyStimulus(w0);
        applyStimulus(w1);
        applyStimulus(w2);
        rts = 1'b0;
        checkOutput("check_rtr", {31'd0, rtr}, 32'd0);
        checkOutput("check_strobe", {31'd0, strobe}, 32'd0);
    endtask

    task automatic expectIssue(input string tag, input logic [15:0] eAddr, input logic [3:0] eR,
                               input logic [3:0] eG, input logic [3:0] eB, input logic [15:0] eWid,
                               input logic [15:0] eHgt, input int stallCycles);
        @(posedge clk);
        #1;
        checkOutput({tag, "_strobe"}, {31'd0, strobe}, 32'd1);
        checkOutput({tag, "_rtr"}, {31'd0, rtr}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_addr"}, {16'd0, initAddr}, {16'd0, eAddr});
        checkOutput({tag, "_rgb"}, {20'd0, rval, gval, bval}, {20'd0, eR, eG, eB});
        checkOutput({tag, "_wid"}, {16'd0, wid}, {16'd0, eWid});
        checkOutput({tag, "_hgt"}, {16'd0, hgt}, {16'd0, eHgt});
        for (int i = 0; i < stallCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_stall_strobe"}, {31'd0, strobe}, 32'd1);
            checkOutput({tag, "_stall_rtr"}, {31'd0, rtr}, 32'd0);
            checkOutput({tag, "_stall_fields"}, {initAddr, wid}, {eAddr, eWid});
        end
        genIdle = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_strobe_off"}, {31'd0, strobe}, 32'd0);
        checkOutput({tag, "_run_busy"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_run_rtr"}, {31'd0, rtr}, 32'd0);
        checkOutput({tag, "_run_fields"}, {initAddr, hgt}, {eAddr, eHgt});
        genIdle = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_rtr"}, {31'd0, rtr}, 32'd1);
        checkOutput({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_drop"}, {24'd0, dropCnt}, 32'(expDrop));
    endtask

    task automatic expectDrop(input string tag);
        expDrop++;
        @(posedge clk);
        #1;
        checkOutput({tag, "_strobe"}, {31'd0, strobe}, 32'd0);
        checkOutput({tag, "_rtr"}, {31'd0, rtr}, 32'd1);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_drop"}, {24'd0, dropCnt}, 32'(expDrop));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rtr"}, {31'd0, rtr}, 32'd0);
        checkOutput({tag, "_strobe"}, {31'd0, strobe}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_drop"}, {24'd0, dropCnt}, 32'd0);
        checkOutput({tag, "_addr"}, {16'd0, initAddr}, 32'd0);
        checkOutput({tag, "_size"}, {wid, hgt}, 32'd0);
        checkOutput({tag, "_rgb"}, {20'd0, rval, gval, bval}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        rts     = 1'b0;
        data    = 32'd0;
        genIdle = 1'b1;

        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rtr_after_reset", {31'd0, rtr}, 32'd1);

        $display("[TB] nominal command with stalled generator");
        sendCmd(32'h1000_0F3A, 32'h0010_0002, 32'h0004_0003);
        expectIssue("nominal", 16'h01E6, 4'hF, 4'h3, 4'hA, 16'd4, 16'd3, 20);

        $display("[TB] bad opcode then valid command");
        applyStimulus(32'h2000_0000);
        rts = 1'b0;
        expDrop++;
        checkOutput("badop_drop", {24'd0, dropCnt}, 32'(expDrop));
        checkOutput("badop_rtr", {31'd0, rtr}, 32'd1);
        checkOutput("badop_busy", {31'd0, busy}, 32'd0);
        sendCmd(32'h1000_0123, 32'h0020_0005, 32'h0007_0009);
        expectIssue("after_badop", 16'h04BC, 4'h1, 4'h2, 4'h3, 16'd7, 16'd9, 0);

        $display("[TB] zero-size commands");
        sendCmd(32'h1000_0555, 32'h0000_0000, 32'h0000_0005);
        expectDrop("zero_wid");
        sendCmd(32'h1000_0555, 32'h0000_0000, 32'h0005_0000);
        expectDrop("zero_hgt");

`ifdef FILL_RECT_CLIP_EN
        $display("[TB] clipping enabled");
        sendCmd(32'h1000_0111, 32'h00E6_0000, 32'h0014_0190);
        expectIssue("clip_partial", 16'h0054, 4'h1, 4'h1, 4'h1, 16'd10, 16'd320, 0);
        sendCmd(32'h1000_0111, 32'h00F0_0000, 32'h0014_0190);
        expectDrop("clip_x_off");
        sendCmd(32'h1000_0111, 32'h0000_0140, 32'h0001_0001);
        expectDrop("clip_y_off");
`else
        $display("[TB] clipping disabled");
        sendCmd(32'h1000_0111, 32'h00E6_0000, 32'h0014_0190);
        expectIssue("noclip_partial", 16'h0054, 4'h1, 4'h1, 4'h1, 16'd20, 16'd400, 0);
        sendCmd(32'h1000_0111, 32'h00F0_0000, 32'h0014_0190);
        expectIssue("noclip_x240", 16'h005A, 4'h1, 4'h1, 4'h1, 16'd20, 16'd400, 0);
        sendCmd(32'h1000_0222, 32'hFFF8_012C, 32'h0001_0001);
        expectIssue("addr_wrap", 16'h793D, 4'h2, 4'h2, 4'h2, 16'd1, 16'd1, 0);
`endif

        $display("[TB] reset mid-command");
        applyStimulus(32'h1000_0777);
        applyStimulus(32'h0003_0004);
        rts = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        rst = 1'b0;
        expDrop = 0;
        sendCmd(32'h1000_0ABC, 32'h0008_0001, 32'h0002_0002);
        expectIssue("post_reset", 16'h00F3, 4'hA, 4'hB, 4'hC, 16'd2, 16'd2, 0);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 254; i++) begin
            applyStimulus(32'hF000_0000);
        end
        rts = 1'b0;
        checkOutput("drop_254", {24'd0, dropCnt}, 32'h0000_00FE);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h0000_0000);
        end
        rts = 1'b0;
        checkOutput("drop_saturated", {24'd0, dropCnt}, 32'h0000_00FF);
        checkOutput("drop_sat_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
